// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and helpers for the DMA bus arbiter
// Holds the two-state FSM encoding, the BUSY counter width and a
// constant-foldable clog2 used to size owner/pointer fields.
package bus_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int CNT_W = 16;

    // Bits needed to hold an index in 0..n-1; loop bound covers n up to 65536.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - one-hot request picker, fixed priority or rotating start
// Ports:
//   i_req  [N-1:0]  request vector
//   i_ptr  [PW-1:0] round-robin start index (ignored when i_mode=0)
//   i_mode          0 = fixed priority (index 0 highest), 1 = round-robin
//   o_gnt  [N-1:0]  one-hot pick, zero when i_req is zero
module arb_pick
    import bus_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_mode,
    output logic [N-1:0]  o_gnt
);

    logic [PW-1:0] w_eff_ptr;
    logic [N-1:0]  w_thr;
    logic [N-1:0]  w_hi;
    logic [N-1:0]  w_hi_low;
    logic [N-1:0]  w_all_low;

    assign w_eff_ptr = i_mode ? i_ptr : '0;

    // Requests at or above the start index get first chance; if none, the
    // search wraps to the lowest set bit of the whole vector.
    assign w_thr = {N{1'b1}} << w_eff_ptr;
    assign w_hi  = i_req & w_thr;

    // v & -v isolates the lowest set bit.
    assign w_hi_low  = w_hi & (~w_hi + N'(1));
    assign w_all_low = i_req & (~i_req + N'(1));

    assign o_gnt = (w_hi != '0) ? w_hi_low : w_all_low;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - DMA bus arbiter with hold-until-ready and BUSY timeout
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   dma     [N-1:0] level-held per-channel requests
//   ready           slave completion strobe for the current transfer
//   grant   [N-1:0] one-hot grant (live pick in IDLE, held in BUSY)
//   req             grant is non-zero
//   owner           binary index of the granted channel, 0 when none
//   timeout         one-cycle pulse after a transfer is aborted
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 8,
    parameter int RR_MODE   = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          dma,
    input  logic                          ready,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          req,
    output logic [clog2(N_MASTERS)-1:0]   owner,
    output logic                          timeout
);

    localparam int OW = clog2(N_MASTERS);
    localparam logic TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [0:0]           r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [OW-1:0]        r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_timeout;

    logic [N_MASTERS-1:0] w_pick;
    logic [OW-1:0]        w_pick_idx;
    logic [OW-1:0]        w_ptr_next;
    logic                 w_busy;
    logic                 w_start;
    logic                 w_expire;
    logic                 w_release;

    function automatic logic [OW-1:0] enc(input logic [N_MASTERS-1:0] v);
        logic [OW-1:0] e;
        e = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (v[i]) begin
                e = e | OW'(i);
            end
        end
        return e;
    endfunction

    arb_pick #(
        .N  (N_MASTERS),
        .PW (OW)
    ) u_pick (
        .i_req  (dma),
        .i_ptr  (r_ptr),
        .i_mode (RR_MODE != 0),
        .o_gnt  (w_pick)
    );

    assign w_busy     = (r_state == ST_BUSY);
    assign w_start    = !w_busy && (w_pick != '0);
    // ready takes precedence over an expiring counter.
    assign w_expire   = w_busy && !ready && TO_EN && (r_cnt == TO_LAST);
    assign w_release  = w_busy && (ready || w_expire);

    assign w_pick_idx = enc(w_pick);
    assign w_ptr_next = (w_pick_idx == OW'(N_MASTERS - 1)) ? '0 : w_pick_idx + OW'(1);

    // Release never re-grants on the same edge: w_start is gated on IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else if (w_start) begin
            r_state <= ST_BUSY;
            r_grant <= w_pick;
        end else if (w_release) begin
            r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if ((RR_MODE != 0) && w_start) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Saturates at all-ones so TIMEOUT=0 can never alias onto a match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_busy && !ready && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
        end
    end

    assign grant   = w_busy ? r_grant : w_pick;
    assign req     = (grant != '0);
    assign owner   = enc(grant);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter (fixed N=8 and round-robin N=4)
module tb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] dma_f;
    logic       ready_f;
    logic [7:0] grant_f;
    logic       req_f;
    logic [2:0] owner_f;
    logic       timeout_f;
    logic [3:0] dma_r;
    logic       ready_r;
    logic [3:0] grant_r;
    logic       req_r;
    logic [1:0] owner_r;
    logic       timeout_r;

    bus_arbiter #(.N_MASTERS(8), .RR_MODE(0), .TIMEOUT(6)) u_fix (
        .clk(clk), .rst(rst), .dma(dma_f), .ready(ready_f),
        .grant(grant_f), .req(req_f), .owner(owner_f), .timeout(timeout_f)
    );

    bus_arbiter #(.N_MASTERS(4), .RR_MODE(1), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst), .dma(dma_r), .ready(ready_r),
        .grant(grant_r), .req(req_r), .owner(owner_r), .timeout(timeout_r)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int grant;
        int owner;
        int req;
        int tout;
    } exp_t;

    exp_t q_f[$];
    exp_t q_r[$];

    // Reference model: per instance, whether a transfer is in progress, who
    // owns it, how many non-ready BUSY cycles have elapsed, and the RR start.
    int mN[2]  = '{8, 4};
    int mRR[2] = '{0, 1};
    int mTO[2] = '{6, 4};
    bit m_busy[2];
    int m_own[2];
    int m_ptr[2];
    int m_bc[2];
    bit m_to[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mpick(input int k, input int d);
        for (int j = 0; j < mN[k]; j++) begin
            int idx;
            idx = (m_ptr[k] + j) % mN[k];
            if (((d >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t mexp(input int k, input int d);
        exp_t e;
        int p;
        if (m_busy[k]) begin
            e.grant = 1 << m_own[k];
            e.owner = m_own[k];
        end else begin
            p = mpick(k, d);
            e.grant = (p >= 0) ? (1 << p) : 0;
            e.owner = (p >= 0) ? p : 0;
        end
        e.req  = (e.grant != 0) ? 1 : 0;
        e.tout = m_to[k] ? 1 : 0;
        return e;
    endfunction

    task automatic mstep(input int k, input int d, input bit r);
        bit nt;
        int p;
        nt = 1'b0;
        if (m_busy[k]) begin
            if (r) begin
                m_busy[k] = 1'b0;
            end else begin
                m_bc[k]++;
                if (mTO[k] != 0 && m_bc[k] == mTO[k]) begin
                    m_busy[k] = 1'b0;
                    nt = 1'b1;
                end
            end
        end else begin
            p = mpick(k, d);
            if (p >= 0) begin
                m_busy[k] = 1'b1;
                m_own[k]  = p;
                m_bc[k]   = 0;
                if (mRR[k] != 0) m_ptr[k] = (p + 1) % mN[k];
            end
        end
        m_to[k] = nt;
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_own[k]  = 0;
            m_ptr[k]  = 0;
            m_bc[k]   = 0;
            m_to[k]   = 1'b0;
        end
    endtask

    // Called shortly after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input int df, input bit rf, input int dr, input bit rr);
        dma_f   = df[7:0];
        ready_f = rf;
        dma_r   = dr[3:0];
        ready_r = rr;
        q_f.push_back(mexp(0, df));
        q_r.push_back(mexp(1, dr));
        @(posedge clk);
        mstep(0, df, rf);
        mstep(1, dr, rr);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_f.size() > 0) begin
            e = q_f.pop_front();
            chk("fix_grant", int'(grant_f), e.grant);
            chk("fix_owner", int'(owner_f), e.owner);
            chk("fix_req", int'(req_f), e.req);
            chk("fix_timeout", int'(timeout_f), e.tout);
        end
        if (q_r.size() > 0) begin
            e = q_r.pop_front();
            chk("rr_grant", int'(grant_r), e.grant);
            chk("rr_owner", int'(owner_r), e.owner);
            chk("rr_req", int'(req_r), e.req);
            chk("rr_timeout", int'(timeout_r), e.tout);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int exp_own[5] = '{0, 1, 2, 3, 0};

    initial begin
        int df;
        int dr;
        int w;
        rst = 1'b1;
        dma_f = '0; ready_f = 1'b0;
        dma_r = '0; ready_r = 1'b0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_f", int'(grant_f), 0);
        chk("rst_req_f", int'(req_f), 0);
        chk("rst_timeout_f", int'(timeout_f), 0);
        chk("rst_grant_r", int'(grant_r), 0);
        chk("rst_timeout_r", int'(timeout_r), 0);
        dma_f = 8'h60;
        #1;
        chk("rst_pick_f", int'(grant_f), 8'h20);
        chk("rst_pick_owner_f", int'(owner_f), 5);
        dma_f = '0;
        rst = 1'b0;

        // First grant right after reset release.
        cycle(8'h08, 1'b0, 0, 1'b0);
        chk("first_grant_f", int'(grant_f), 8'h08);
        chk("first_owner_f", int'(owner_f), 3);
        cycle(0, 1'b1, 0, 1'b0);

        // No requests, ready toggling: nothing granted, no timeout.
        for (int i = 0; i < 10; i++) begin
            cycle(0, i[0], 0, ~i[0]);
            chk("idle_req_f", int'(req_f), 0);
            chk("idle_timeout_r", int'(timeout_r), 0);
        end

        // Fixed priority: lowest index wins, held through dma changes.
        cycle(8'hA4, 1'b0, 0, 1'b0);
        chk("fix_hold_grant", int'(grant_f), 8'h04);
        chk("fix_hold_owner", int'(owner_f), 2);
        cycle(8'h01, 1'b0, 0, 1'b0);
        cycle(8'h01, 1'b0, 0, 1'b0);
        chk("fix_hold_grant2", int'(grant_f), 8'h04);
        cycle(8'h01, 1'b1, 0, 1'b0);
        chk("fix_rearb_grant", int'(grant_f), 8'h01);
        chk("fix_rearb_owner", int'(owner_f), 0);
        cycle(0, 1'b0, 0, 1'b0);

        // Round-robin rotation with all channels requesting.
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1'b0, 4'hF, 1'b0);
            chk("rr_rot_owner", int'(owner_r), exp_own[k]);
            chk("rr_rot_req", int'(req_r), 1);
            cycle(0, 1'b0, 4'hF, 1'b1);
        end

        // Timeout: channel 1 granted, ready never comes.
        cycle(0, 1'b0, 4'h2, 1'b0);
        chk("to_owner", int'(owner_r), 1);
        repeat (3) cycle(0, 1'b0, 0, 1'b0);
        chk("to_early_timeout", int'(timeout_r), 0);
        chk("to_early_req", int'(req_r), 1);
        cycle(0, 1'b0, 0, 1'b0);
        chk("to_pulse", int'(timeout_r), 1);
        chk("to_released", int'(req_r), 0);
        cycle(0, 1'b0, 4'h2, 1'b0);
        chk("to_pulse_end", int'(timeout_r), 0);
        chk("to_regrant", int'(owner_r), 1);
        cycle(0, 1'b0, 0, 1'b1);

        // ready in the last BUSY cycle beats the timeout.
        cycle(0, 1'b0, 4'h2, 1'b0);
        repeat (3) cycle(0, 1'b0, 0, 1'b0);
        cycle(0, 1'b0, 0, 1'b1);
        chk("rdy_win_timeout", int'(timeout_r), 0);
        chk("rdy_win_req", int'(req_r), 0);
        cycle(0, 1'b0, 0, 1'b0);
        chk("rdy_win_timeout2", int'(timeout_r), 0);

        // Asynchronous reset in the middle of a transfer.
        cycle(8'hA4, 1'b0, 4'h2, 1'b0);
        dma_f = 8'h30;
        dma_r = 4'h8;
        #1;
        chk("arst_pre_grant_f", int'(grant_f), 8'h04);
        rst = 1'b1;
        #1;
        chk("arst_grant_f", int'(grant_f), 8'h10);
        chk("arst_owner_f", int'(owner_f), 4);
        chk("arst_grant_r", int'(grant_r), 8);
        chk("arst_owner_r", int'(owner_r), 3);
        chk("arst_timeout_r", int'(timeout_r), 0);
        chk("arst_ptr_r", int'(u_rr.r_ptr), 0);
        chk("arst_state_r", int'(u_rr.r_state), 0);
        chk("arst_greg_f", int'(u_fix.r_grant), 0);
        mreset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dma_f = '0;
        dma_r = '0;

        // Randomized traffic against the model.
        repeat (3000) begin
            df = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
            dr = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            cycle(df, ($urandom_range(0, 3) == 0), dr, ($urandom_range(0, 3) == 0));
        end

        w = 0;
        while ((q_f.size() > 0 || q_r.size() > 0) && w < 10) begin
            @(negedge clk);
            w++;
        end
        #1;
        chk("drain_f", q_f.size(), 0);
        chk("drain_r", q_r.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 8: number of DMA request channels, legal range 2..32.
REQ-002 Parameter RR_MODE, default 0: 0 selects fixed priority (channel 0 highest); 1 selects round-robin.
REQ-003 Parameter TIMEOUT, default 255: maximum BUSY cycles without ready, legal range 1..65535; 0 disables timeout.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 dma  input  N_MASTERS  per-channel bus request, level-held by the master.
REQ-007 ready  input  1  slave completion strobe for the current transfer.
REQ-008 grant  output  N_MASTERS  one-hot grant vector, or all zeros.
REQ-009 req  output  1  high whenever grant is non-zero.
REQ-010 owner  output  clog2(N_MASTERS)  binary index of the granted channel; 0 when grant is zero.
REQ-011 timeout  output  1  one-cycle pulse when a transfer is aborted by the timeout counter.

Function
REQ-012 The state machine SHALL have two states: IDLE and BUSY.
REQ-013 In IDLE, grant SHALL be the combinational pick of dma, and SHALL be zero when dma is zero.
- Fixed mode: lowest set index wins.
- RR mode: first set index at or above ptr wins, wrapping modulo N_MASTERS.
REQ-014 In IDLE, on a rising edge with a non-zero pick, the block SHALL register the pick into grant_reg and enter BUSY; with a zero pick it SHALL stay in IDLE and leave grant_reg unchanged.
REQ-015 In BUSY, grant SHALL equal grant_reg regardless of dma changes, including deassertion by the owner.
REQ-016 In BUSY, ready=1 at a rising edge SHALL return the block to IDLE; ready in IDLE SHALL be ignored.
REQ-017 In RR mode, ptr SHALL load (owner+1) mod N_MASTERS on the edge that enters BUSY; ptr SHALL be constant in fixed mode.
REQ-018 A counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready.
REQ-019 If the counter equals TIMEOUT-1 and ready=0 (TIMEOUT≠0), the block SHALL return to IDLE and pulse timeout for exactly the following cycle.
REQ-020 If ready and the timeout condition coincide, ready SHALL win and timeout SHALL stay low.
REQ-021 On return to IDLE, the same edge SHALL NOT grant again; the next grant SHALL be decided from dma in the IDLE cycle, so minimum back-to-back spacing is one IDLE cycle.
REQ-022 The counter width SHALL be 16 bits; it SHALL saturate and never wrap.
REQ-023 owner and req SHALL be combinational functions of grant.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, grant_reg=0, ptr=0, counter=0 and timeout=0, independent of clk.
REQ-025 Reset asserted mid-BUSY SHALL drop grant to the IDLE pick of dma, with no timeout pulse.
REQ-026 The first grant after reset deasserts SHALL occur on the first rising edge with rst=0 and dma≠0.

Structure
REQ-027 A shared package bus_pkg SHALL hold the state encoding (IDLE=0, BUSY=1), the counter width constant, and a clog2 function.
REQ-028 The pick logic SHALL be one sub-module, arb_pick (inputs: request vector, ptr, mode; output: one-hot vector), instantiated once.
REQ-029 RTL SHALL be synthesizable, with no latches and one always block per register group.

Verification
REQ-030 Fixed mode, N=8: dma=8'b1010_0100 → grant=8'b0000_0100, owner=2; dma changes to 8'b0000_0001 while BUSY → grant unchanged until ready.
REQ-031 RR mode, N=4: dma=4'b1111 held, ready pulsed each transfer → owners 0,1,2,3,0 in order, with one IDLE cycle between grants.
REQ-032 TIMEOUT=4: grant channel 1, ready never asserted → IDLE after 4 BUSY cycles, timeout high for exactly 1 cycle, then re-arbitration.
REQ-033 TIMEOUT=4: ready asserted in the 4th BUSY cycle → normal release, timeout stays 0.
REQ-034 rst asserted asynchronously mid-BUSY (between edges) → grant_reg, ptr and state clear before the next clk edge; grant follows dma pick.
REQ-035 dma=0 for 10 cycles, with ready toggling → grant=0, req=0, state stays IDLE, no timeout pulse.
